switch_debounce: RTL

- Input conditioner for the hardware switch bank. It sits directly upstream of the APB switch register slave and drives that slave's i_switch_value.
- Each raw, asynchronous switch bit is synchronised into the PCLK domain, then debounced with its own counter.
- Outputs are a registered, glitch-free switch vector plus one-cycle change indications. Software therefore reads only settled values.

---
 rtl/switch_debounce.sv | 72 +++++++
 1 files changed

// File: rtl/switch_debounce.sv
`timescale 1ns/1ps
// Switch-bank input conditioner: per-bit synchroniser followed by a saturating
// debounce counter, giving a settled vector plus one-cycle rise/fall pulses.
module switch_debounce #(
  parameter int               WIDTH           = 32,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [WIDTH-1:0] i_switch_raw,
  output logic [WIDTH-1:0] o_switch_value,
  output logic [WIDTH-1:0] o_rise_mask,
  output logic [WIDTH-1:0] o_fall_mask,
  output logic             o_change
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_p0 [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [CNT_W-1:0] cnt_p1  [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0] flip;

  // Count clears on agreement and on the flip edge, so it can never pass CNT_LAST.
  function automatic logic [CNT_W-1:0] cnt_step(input logic diff,
                                                input logic [CNT_W-1:0] cnt);
    if (!diff || cnt == CNT_LAST) return '0;
    return cnt + CNT_W'(1);
  endfunction

  // Stage 0: synchroniser chain into the PCLK domain
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p0[s] <= RESET_VALUE;
    end else begin
      sync_p0[0] <= i_switch_raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p0[s] <= sync_p0[s-1];
    end
  end

  assign sync_q = sync_p0[SYNC_STAGES-1];

  always_comb begin
    flip = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt_step(sync_q[i] ^ o_switch_value[i], cnt_p1[i]);
      flip[i]    = (sync_q[i] ^ o_switch_value[i]) && (cnt_p1[i] == CNT_LAST);
    end
  end

  // Stage 1: debounce counters, settled vector and edge pulses
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < WIDTH; i++) cnt_p1[i] <= '0;
      o_switch_value <= RESET_VALUE;
      o_rise_mask    <= '0;
      o_fall_mask    <= '0;
      o_change       <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_p1[i] <= cnt_nxt[i];
      o_switch_value <= o_switch_value ^ flip;
      o_rise_mask    <= flip & sync_q;
      o_fall_mask    <= flip & ~sync_q;
      o_change       <= |flip;
    end
  end

endmodule
